// File: rtl/mem_input_logic.sv
// Data-memory request formatter: turns byte-addressed loads/stores into
// word-aligned beats with byte enables, splitting word-crossing accesses.
module mem_input_logic (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  memOp,
    input  logic [1:0]  memSize,
    output logic        memReq,
    input  logic        memAck,
    output logic [31:0] memAddr,
    output logic        memWe,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    output logic        split,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t      state, stateNext;
    logic [3:0]  hiBe, hiBeNext;
    logic [31:0] hiData, hiDataNext;
    logic        reqNext, weNext, splitNext, doneNext;
    logic [3:0]  beNext;
    logic [31:0] addrNext, wdataNext;

    logic        opValid, isStore;
    logic [3:0]  sizeMask;
    logic [31:0] sizedData;
    logic [7:0]  laneMask;
    logic [63:0] laneData;

    assign opValid = (memOp == 2'b01) || (memOp == 2'b10);
    assign isStore = (memOp == 2'b10);
    assign inReady = (state == IDLE);

    always_comb begin
        case (memSize)
            2'b00:   begin sizeMask = 4'b0001; sizedData = {24'b0, wdata[7:0]};  end
            2'b01:   begin sizeMask = 4'b0011; sizedData = {16'b0, wdata[15:0]}; end
            default: begin sizeMask = 4'b1111; sizedData = wdata;                end
        endcase
        laneMask = {4'b0, sizeMask} << addr[1:0];
        laneData = {32'b0, sizedData} << {addr[1:0], 3'b000};
    end

    always_comb begin
        stateNext  = state;
        reqNext    = memReq;
        addrNext   = memAddr;
        weNext     = memWe;
        beNext     = memBe;
        wdataNext  = memWdata;
        splitNext  = split;
        hiBeNext   = hiBe;
        hiDataNext = hiData;
        doneNext   = 1'b0;
        case (state)
            IDLE: begin
                if (inValid && opValid) begin
                    stateNext  = BEAT0;
                    reqNext    = 1'b1;
                    addrNext   = {addr[31:2], 2'b00};
                    weNext     = isStore;
                    beNext     = laneMask[3:0];
                    wdataNext  = isStore ? laneData[31:0] : '0;
                    splitNext  = (laneMask[7:4] != 4'b0000);
                    hiBeNext   = laneMask[7:4];
                    hiDataNext = isStore ? laneData[63:32] : '0;
                end
            end
            BEAT0: begin
                if (memAck) begin
                    if (split) begin
                        stateNext = BEAT1;
                        addrNext  = memAddr + 32'd4;
                        beNext    = hiBe;
                        wdataNext = hiData;
                    end else begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (memAck) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Leaving for IDLE drops the request and clears the beat fields.
        if (doneNext) begin
            reqNext   = 1'b0;
            weNext    = 1'b0;
            beNext    = '0;
            wdataNext = '0;
            splitNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memAddr  <= '0;
            memWe    <= 1'b0;
            memBe    <= '0;
            memWdata <= '0;
            split    <= 1'b0;
            done     <= 1'b0;
            hiBe     <= '0;
            hiData   <= '0;
        end else begin
            state    <= stateNext;
            memReq   <= reqNext;
            memAddr  <= addrNext;
            memWe    <= weNext;
            memBe    <= beNext;
            memWdata <= wdataNext;
            split    <= splitNext;
            done     <= doneNext;
            hiBe     <= hiBeNext;
            hiData   <= hiDataNext;
        end
    end

endmodule

// File: tb/tb_mem_input_logic.sv
// Directed bench for mem_input_logic with hand-computed beat expectations.
module tb_mem_input_logic;

    logic        clk = 1'b0;
    logic        resetn, inValid, inReady;
    logic [31:0] addr, wdata;
    logic [1:0]  memOp, memSize;
    logic        memReq, memAck, memWe, split, done;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memBe;

    int passCnt = 0;
    int totalCnt = 0;

    mem_input_logic dut (
        .clk(clk), .resetn(resetn), .inValid(inValid), .inReady(inReady),
        .addr(addr), .wdata(wdata), .memOp(memOp), .memSize(memSize),
        .memReq(memReq), .memAck(memAck), .memAddr(memAddr), .memWe(memWe),
        .memBe(memBe), .memWdata(memWdata), .split(split), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chkBeat(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d, input logic we, input logic sp);
        chk({tag, ".req"},   {31'b0, memReq}, 32'd1);
        chk({tag, ".addr"},  memAddr, a);
        chk({tag, ".be"},    {28'b0, memBe}, {28'b0, be});
        chk({tag, ".wdata"}, memWdata, d);
        chk({tag, ".we"},    {31'b0, memWe}, {31'b0, we});
        chk({tag, ".split"}, {31'b0, split}, {31'b0, sp});
        chk({tag, ".ready"}, {31'b0, inReady}, 32'd0);
        chk({tag, ".done"},  {31'b0, done}, 32'd0);
    endtask

    task automatic chkDone(input string tag);
        chk({tag, ".done"},  {31'b0, done}, 32'd1);
        chk({tag, ".req"},   {31'b0, memReq}, 32'd0);
        chk({tag, ".ready"}, {31'b0, inReady}, 32'd1);
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] op, input logic [1:0] sz);
        inValid = 1'b1; addr = a; wdata = d; memOp = op; memSize = sz;
    endtask

    initial begin
        resetn = 1'b0; inValid = 1'b0; addr = '0; wdata = '0;
        memOp = 2'b00; memSize = 2'b00; memAck = 1'b0;
        tick(); tick();
        chk("rst.req",   {31'b0, memReq}, 32'd0);
        chk("rst.addr",  memAddr, 32'd0);
        chk("rst.be",    {28'b0, memBe}, 32'd0);
        chk("rst.wdata", memWdata, 32'd0);
        chk("rst.we",    {31'b0, memWe}, 32'd0);
        chk("rst.split", {31'b0, split}, 32'd0);
        chk("rst.done",  {31'b0, done}, 32'd0);
        chk("rst.ready", {31'b0, inReady}, 32'd1);
        resetn = 1'b1;
        memAck = 1'b1;
        tick();

        // Aligned word store, ack tied high.
        present(32'h100, 32'hDEADBEEF, 2'b10, 2'b10);
        tick();
        inValid = 1'b0;
        chkBeat("wst", 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1, 1'b0);
        tick();
        chkDone("wst");
        tick();
        chk("wst.doneLow", {31'b0, done}, 32'd0);

        // Byte store into top lane.
        present(32'h203, 32'h000000A5, 2'b10, 2'b00);
        tick();
        inValid = 1'b0;
        chkBeat("bst", 32'h200, 4'b1000, 32'hA5000000, 1'b1, 1'b0);
        tick();
        chkDone("bst");
        tick();

        // Unaligned word store, two back-to-back beats.
        present(32'h102, 32'h11223344, 2'b10, 2'b10);
        tick();
        inValid = 1'b0;
        chkBeat("ust0", 32'h100, 4'b1100, 32'h33440000, 1'b1, 1'b1);
        tick();
        chkBeat("ust1", 32'h104, 4'b0011, 32'h00001122, 1'b1, 1'b1);
        tick();
        chkDone("ust");
        tick();
        chk("ust.doneOnce", {31'b0, done}, 32'd0);

        // Half load wrapping the address space, ack delayed.
        memAck = 1'b0;
        present(32'hFFFFFFFF, 32'h0000ABCD, 2'b01, 2'b01);
        tick();
        present(32'h12345678, 32'hFFFFFFFF, 2'b10, 2'b10);
        for (int i = 0; i < 3; i++) begin
            chkBeat("hld0", 32'hFFFFFFFC, 4'b1000, 32'h0, 1'b0, 1'b1);
            if (i == 2) memAck = 1'b1;
            tick();
        end
        memAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chkBeat("hld1", 32'h00000000, 4'b0001, 32'h0, 1'b0, 1'b1);
            if (i == 2) memAck = 1'b1;
            tick();
        end
        inValid = 1'b0;
        chkDone("hld");
        tick();

        // No-op and reserved ops are consumed silently.
        present(32'h300, 32'h1, 2'b00, 2'b10);
        tick();
        chk("nop.req",   {31'b0, memReq}, 32'd0);
        chk("nop.done",  {31'b0, done}, 32'd0);
        chk("nop.ready", {31'b0, inReady}, 32'd1);
        present(32'h300, 32'h1, 2'b11, 2'b10);
        tick();
        chk("rsv.req",   {31'b0, memReq}, 32'd0);
        chk("rsv.done",  {31'b0, done}, 32'd0);
        chk("rsv.ready", {31'b0, inReady}, 32'd1);
        present(32'h40, 32'h12345678, 2'b10, 2'b10);
        tick();
        inValid = 1'b0;
        chkBeat("afn", 32'h40, 4'b1111, 32'h12345678, 1'b1, 1'b0);
        tick();
        chkDone("afn");
        tick();

        // Reset while waiting in the second beat.
        present(32'h001, 32'hAABBCCDD, 2'b10, 2'b10);
        tick();
        inValid = 1'b0;
        chkBeat("rs0", 32'h0, 4'b1110, 32'hBBCCDD00, 1'b1, 1'b1);
        tick();
        memAck = 1'b0;
        chkBeat("rs1", 32'h4, 4'b0001, 32'h000000AA, 1'b1, 1'b1);
        tick();
        chkBeat("rs1w", 32'h4, 4'b0001, 32'h000000AA, 1'b1, 1'b1);
        resetn = 1'b0;
        memAck = 1'b1;
        tick();
        resetn = 1'b1;
        memAck = 1'b0;
        chk("rsa.req",   {31'b0, memReq}, 32'd0);
        chk("rsa.be",    {28'b0, memBe}, 32'd0);
        chk("rsa.split", {31'b0, split}, 32'd0);
        chk("rsa.ready", {31'b0, inReady}, 32'd1);
        chk("rsa.done",  {31'b0, done}, 32'd0);
        tick();
        chk("rsb.done",  {31'b0, done}, 32'd0);
        chk("rsb.req",   {31'b0, memReq}, 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
